lif_neuron: RTL and testbench

Parametrised leaky integrate-and-fire neuron. It is the next-generation replacement for the fixed 3-input, fixed-constant neuron used in the spiking network's hidden and output layers. It adds:
- an N-input weighted sum with runtime-writable weights
- runtime membrane constants
- an absolute refractory period
- a tick enable
- asynchronous reset

One instance per neuron. Network modules wire layer outputs to `spike_in` buses.

---
 rtl/snn_pkg.sv | 18 +
 rtl/spike_weight_sum.sv | 27 ++
 rtl/lif_neuron.sv | 121 ++++++++++++
 tb/tb_lif_neuron.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and width helpers for the spiking-network neuron blocks.
package snn_pkg;

  typedef enum logic {
    INTEG  = 1'b0,
    REFRAC = 1'b1
  } neuron_state_t;

  localparam int W_W_DEF      = 3;
  localparam int V_W_DEF      = 5;
  localparam int REFRAC_W_DEF = 3;

  // Width that holds the sum of n_in weights of w_w bits without overflow.
  function automatic int sum_width(input int n_in, input int w_w);
    return w_w + $clog2(n_in + 1);
  endfunction

endpackage

// File: rtl/spike_weight_sum.sv
// Combinational adder of the weights whose presynaptic spike bit is set.
module spike_weight_sum
  import snn_pkg::*;
#(
  parameter  int N_IN  = 3,
  parameter  int W_W   = W_W_DEF,
  localparam int SUM_W = sum_width(N_IN, W_W)
) (
  input  logic [N_IN*W_W-1:0] weights_i,
  input  logic [N_IN-1:0]     spike_i,
  output logic [SUM_W-1:0]    sum_o
);

  logic [SUM_W-1:0] term [N_IN];

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_term
    assign term[gi] = spike_i[gi] ? SUM_W'(weights_i[gi*W_W +: W_W]) : '0;
  end

  always_comb begin
    sum_o = '0;
    for (int i = 0; i < N_IN; i++) begin
      sum_o = sum_o + term[i];
    end
  end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with writable weights, runtime membrane
// constants, tick enable and an absolute refractory period.
module lif_neuron
  import snn_pkg::*;
#(
  parameter  int N_IN     = 3,
  parameter  int W_W      = W_W_DEF,
  parameter  int V_W      = V_W_DEF,
  parameter  int REFRAC_W = REFRAC_W_DEF,
  localparam int A_W      = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [N_IN-1:0]     spike_in,
  input  logic                cfg_we,
  input  logic [A_W-1:0]      cfg_addr,
  input  logic [W_W-1:0]      cfg_wdata,
  input  logic [V_W-1:0]      v_rest,
  input  logic [V_W-1:0]      v_leak,
  input  logic [V_W-1:0]      v_thresh,
  input  logic [REFRAC_W-1:0] refrac_len,
  output logic                spike_out,
  output logic [V_W-1:0]      v_mem,
  output logic                refractory
);

  localparam int SUM_W = sum_width(N_IN, W_W);
  localparam int VN_W  = ((V_W > SUM_W) ? V_W : SUM_W) + 2;

  logic [W_W-1:0]      weight_q [N_IN];
  logic [N_IN*W_W-1:0] weight_bus;
  logic [SUM_W-1:0]    syn_sum;

  neuron_state_t       state_q, state_d;
  logic [REFRAC_W-1:0] cnt_q, cnt_d;
  logic [V_W-1:0]      v_mem_q, v_mem_d;
  logic                spike_q, spike_d;

  logic signed [VN_W-1:0] v_next, thresh_s, rest_s;

  // Out-of-range addresses match no entry, so they are dropped naturally.
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_weight
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        weight_q[gi] <= '0;
      end else if (cfg_we && cfg_addr == A_W'(gi)) begin
        weight_q[gi] <= cfg_wdata;
      end
    end
    assign weight_bus[gi*W_W +: W_W] = weight_q[gi];
  end

  spike_weight_sum #(
    .N_IN (N_IN),
    .W_W  (W_W)
  ) u_sum (
    .weights_i (weight_bus),
    .spike_i   (spike_in),
    .sum_o     (syn_sum)
  );

  always_comb begin
    v_next   = VN_W'(v_mem_q) + VN_W'(syn_sum) - VN_W'(v_leak);
    thresh_s = VN_W'(v_thresh);
    rest_s   = VN_W'(v_rest);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    v_mem_d = v_mem_q;
    spike_d = 1'b0;
    if (en) begin
      case (state_q)
        INTEG: begin
          // Threshold wins over the floor clamp, even if v_rest >= v_thresh.
          if (v_next >= thresh_s) begin
            spike_d = 1'b1;
            v_mem_d = v_rest;
            if (refrac_len != '0) begin
              state_d = REFRAC;
              cnt_d   = refrac_len;
            end
          end else if (v_next < rest_s) begin
            v_mem_d = v_rest;
          end else begin
            v_mem_d = v_next[V_W-1:0];
          end
        end
        REFRAC: begin
          v_mem_d = v_rest;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == REFRAC_W'(1)) begin
            state_d = INTEG;
          end
        end
        default: state_d = INTEG;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INTEG;
      cnt_q   <= '0;
      v_mem_q <= '0;
      spike_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v_mem_q <= v_mem_d;
      spike_q <= spike_d;
    end
  end

  assign spike_out  = spike_q;
  assign v_mem      = v_mem_q;
  assign refractory = (state_q == REFRAC);

endmodule

// File: tb/tb_lif_neuron.sv
// Self-checking bench for lif_neuron: directed vector table, async-reset
// sequence, then randomized ticks against an integer reference model.
module tb_lif_neuron;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] spike_in = '0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [2:0] cfg_wdata = '0;
  logic [4:0] v_rest = 5'd6;
  logic [4:0] v_leak = 5'd1;
  logic [4:0] v_thresh = 5'd14;
  logic [2:0] refrac_len = '0;
  logic       spike_out;
  logic [4:0] v_mem;
  logic       refractory;

  int total = 0;
  int bad = 0;

  // reference model: remaining refractory ticks replaces an explicit state
  int m_v, m_cnt, m_spk;
  int m_w [3];

  always #5 clk = ~clk;

  lif_neuron #(.N_IN(3), .W_W(3), .V_W(5), .REFRAC_W(3)) dut (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .v_rest(v_rest), .v_leak(v_leak), .v_thresh(v_thresh),
    .refrac_len(refrac_len), .spike_out(spike_out), .v_mem(v_mem),
    .refractory(refractory)
  );

  typedef struct {
    bit       e;
    bit [2:0] s;
    bit       we;
    bit [1:0] a;
    bit [2:0] d;
    bit [2:0] rl;
    int       ev;
    int       es;
    int       er;
  } vec_t;

  vec_t tv [$];

  function automatic vec_t mk(bit e, bit [2:0] s, bit we, bit [1:0] a, bit [2:0] d,
                              bit [2:0] rl, int ev, int es, int er);
    vec_t v;
    v.e = e; v.s = s; v.we = we; v.a = a; v.d = d; v.rl = rl;
    v.ev = ev; v.es = es; v.er = er;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_v = 0; m_cnt = 0; m_spk = 0;
    for (int i = 0; i < 3; i++) m_w[i] = 0;
  endtask

  task automatic model_tick(input bit e, input bit [2:0] s, input bit we,
                            input bit [1:0] a, input bit [2:0] d);
    int sum, vn;
    sum = 0;
    for (int i = 0; i < 3; i++) if (s[i]) sum += m_w[i];
    m_spk = 0;
    if (e) begin
      if (m_cnt > 0) begin
        m_v = v_rest;
        m_cnt--;
      end else begin
        vn = m_v + sum - int'(v_leak);
        if (vn >= int'(v_thresh)) begin
          m_spk = 1;
          m_v = v_rest;
          m_cnt = refrac_len;
        end else if (vn < int'(v_rest)) begin
          m_v = v_rest;
        end else begin
          m_v = vn;
        end
      end
    end
    if (we && a < 3) m_w[a] = d;
  endtask

  task automatic step(input bit e, input bit [2:0] s, input bit we,
                      input bit [1:0] a, input bit [2:0] d);
    en = e; spike_in = s; cfg_we = we; cfg_addr = a; cfg_wdata = d;
    model_tick(e, s, we, a, d);
    @(posedge clk);
    #1;
    en = 1'b0; cfg_we = 1'b0;
  endtask

  initial begin
    model_reset();
    #12 rst = 1'b0;
    #1;
    chk("reset v_mem", v_mem, 0);
    chk("reset spike_out", spike_out, 0);
    chk("reset refractory", refractory, 0);
    @(posedge clk); #1;

    // directed plan: each row is one clk edge
    tv.push_back(mk(0, 3'b000, 1, 2'd0, 3'd3, 0, 0, 0, 0));
    tv.push_back(mk(0, 3'b000, 1, 2'd1, 3'd3, 0, 0, 0, 0));
    tv.push_back(mk(0, 3'b000, 1, 2'd2, 3'd2, 0, 0, 0, 0));
    tv.push_back(mk(1, 3'b111, 0, 2'd0, 3'd0, 0, 7, 0, 0));
    tv.push_back(mk(1, 3'b111, 0, 2'd0, 3'd0, 0, 6, 1, 0));
    tv.push_back(mk(1, 3'b001, 0, 2'd0, 3'd0, 0, 8, 0, 0));
    tv.push_back(mk(1, 3'b100, 0, 2'd0, 3'd0, 0, 9, 0, 0));
    tv.push_back(mk(1, 3'b000, 0, 2'd0, 3'd0, 0, 8, 0, 0));
    tv.push_back(mk(1, 3'b000, 0, 2'd0, 3'd0, 0, 7, 0, 0));
    tv.push_back(mk(1, 3'b000, 0, 2'd0, 3'd0, 0, 6, 0, 0));
    tv.push_back(mk(1, 3'b000, 0, 2'd0, 3'd0, 0, 6, 0, 0));
    tv.push_back(mk(1, 3'b001, 1, 2'd0, 3'd7, 0, 8, 0, 0));
    tv.push_back(mk(1, 3'b001, 0, 2'd0, 3'd0, 0, 6, 1, 0));
    for (int i = 0; i < 5; i++) tv.push_back(mk(0, 3'b111, 0, 2'd0, 3'd0, 0, 6, 0, 0));
    tv.push_back(mk(0, 3'b000, 1, 2'd3, 3'd7, 0, 6, 0, 0));
    tv.push_back(mk(1, 3'b100, 0, 2'd0, 3'd0, 0, 7, 0, 0));
    tv.push_back(mk(0, 3'b000, 1, 2'd0, 3'd3, 2, 7, 0, 0));
    tv.push_back(mk(1, 3'b111, 0, 2'd0, 3'd0, 2, 6, 1, 1));
    tv.push_back(mk(1, 3'b111, 0, 2'd0, 3'd0, 2, 6, 0, 1));
    tv.push_back(mk(1, 3'b111, 0, 2'd0, 3'd0, 2, 6, 0, 0));
    tv.push_back(mk(1, 3'b111, 0, 2'd0, 3'd0, 2, 13, 0, 0));
    tv.push_back(mk(1, 3'b111, 0, 2'd0, 3'd0, 2, 6, 1, 1));

    for (int i = 0; i < tv.size(); i++) begin
      refrac_len = tv[i].rl;
      step(tv[i].e, tv[i].s, tv[i].we, tv[i].a, tv[i].d);
      $display("vec %0d: en=%0b spk=%b we=%0b v_mem=%0d spike=%0b refr=%0b",
               i, tv[i].e, tv[i].s, tv[i].we, v_mem, spike_out, refractory);
      chk($sformatf("vec%0d v_mem", i), v_mem, tv[i].ev);
      chk($sformatf("vec%0d spike_out", i), spike_out, tv[i].es);
      chk($sformatf("vec%0d refractory", i), refractory, tv[i].er);
    end

    // async reset mid-pulse and mid-refractory, between clock edges
    #1 rst = 1'b1;
    #1;
    $display("async reset: v_mem=%0d spike=%0b refr=%0b", v_mem, spike_out, refractory);
    chk("async rst v_mem", v_mem, 0);
    chk("async rst spike_out", spike_out, 0);
    chk("async rst refractory", refractory, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    step(1, 3'b111, 0, 2'd0, 3'd0);
    $display("post reset tick: v_mem=%0d spike=%0b", v_mem, spike_out);
    chk("post rst v_mem", v_mem, 6);
    chk("post rst spike_out", spike_out, 0);
    step(1, 3'b111, 0, 2'd0, 3'd0);
    chk("post rst weights zero", v_mem, 6);

    // randomized ticks against the reference model
    for (int i = 0; i < 400; i++) begin
      bit e, we;
      bit [2:0] s, d;
      bit [1:0] a;
      e  = ($urandom_range(0, 9) != 0);
      s  = 3'($urandom);
      we = ($urandom_range(0, 3) == 0);
      a  = 2'($urandom);
      d  = 3'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        v_rest   = 5'($urandom_range(0, 10));
        v_leak   = 5'($urandom_range(0, 4));
        v_thresh = 5'($urandom_range(8, 31));
      end
      refrac_len = 3'($urandom);
      step(e, s, we, a, d);
      $display("rnd %0d: en=%0b spk=%b we=%0b a=%0d d=%0d v_mem=%0d/%0d spike=%0b/%0d refr=%0b/%0d",
               i, e, s, we, a, d, v_mem, m_v, spike_out, m_spk, refractory, (m_cnt > 0));
      chk($sformatf("rnd%0d v_mem", i), v_mem, m_v);
      chk($sformatf("rnd%0d spike_out", i), spike_out, m_spk);
      chk($sformatf("rnd%0d refractory", i), refractory, (m_cnt > 0) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
